// File: rtl/ahb_dbg_pkg.sv
// rtl/ahb_dbg_pkg.sv - shared types and widths for the JTAG-to-AHB debug path
package ahb_dbg_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CMD_W  = 2;
    localparam int DR_W   = CMD_W + DATA_W;

    // Bit positions of the status flags inside the captured command field
    localparam int ST_BUSY = 0;
    localparam int ST_ERR  = 1;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_SETADDR = 2'b01,
        CMD_WRITE   = 2'b10,
        CMD_READ    = 2'b11
    } cmd_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/ahb_dr_shift.sv
// rtl/ahb_dr_shift.sv - TCK-domain AHB access data register; optional AHB_DR_AUTOINC_EN
// bumps the address by 4 on every completed transfer.
module ahb_dr_shift
    import ahb_dbg_pkg::*;
#(
    parameter int ADDR_W = ahb_dbg_pkg::ADDR_W,
    parameter int DATA_W = ahb_dbg_pkg::DATA_W,
    parameter int CMD_W  = ahb_dbg_pkg::CMD_W
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              TDI,
    input  logic              ahb_select,
    input  logic              dr_capture,
    input  logic              dr_shift,
    input  logic              dr_update,
    output logic              tdo,
    output logic              req,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              ack,
    input  logic              ack_error,
    input  logic [DATA_W-1:0] ack_rdata,
    output logic              busy
);

    localparam int DR_LEN = CMD_W + DATA_W;

    logic [DR_LEN-1:0] sr,      sr_n;
    logic [ADDR_W-1:0] addr_q,  addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic              err_q,   err_n;
    logic              write_q, write_n;
    state_t            state,   state_n;

    cmd_t              cmd;
    logic [DATA_W-1:0] payload;
    logic [CMD_W-1:0]  status;

    assign cmd     = cmd_t'(sr[DR_LEN-1:DATA_W]);
    assign payload = sr[DATA_W-1:0];

    always_comb begin
        status          = '0;
        status[ST_ERR]  = err_q;
        status[ST_BUSY] = (state == PEND);
    end

    always_comb begin
        sr_n    = sr;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        rdata_n = rdata_q;
        err_n   = err_q;
        write_n = write_q;
        state_n = state;

        // Completion is handled first so a same-cycle update sees IDLE.
        if (state == PEND && ack) begin
            state_n = IDLE;
            if (!write_q) begin
                rdata_n = ack_rdata;
            end
            err_n = err_q | ack_error;
`ifdef AHB_DR_AUTOINC_EN
            addr_n = addr_q + ADDR_W'(4);
`endif
        end

        if (ahb_select) begin
            if (dr_capture) begin
                sr_n = {status, rdata_q};
                // Error is sticky while a transfer is outstanding.
                if (state == IDLE) begin
                    err_n = 1'b0;
                end
            end else if (dr_shift) begin
                sr_n = {TDI, sr[DR_LEN-1:1]};
            end

            if (dr_update) begin
                case (cmd)
                    CMD_SETADDR: addr_n = payload[ADDR_W-1:0];
                    CMD_WRITE, CMD_READ: begin
                        if (state_n == PEND) begin
                            err_n = 1'b1;
                        end else begin
                            state_n = PEND;
                            write_n = (cmd == CMD_WRITE);
                            if (cmd == CMD_WRITE) begin
                                wdata_n = payload;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            sr      <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            state   <= IDLE;
        end else begin
            sr      <= sr_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
            write_q <= write_n;
            state   <= state_n;
        end
    end

    assign tdo       = sr[0];
    assign req       = (state == PEND);
    assign busy      = req;
    assign req_write = write_q;
    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;

endmodule

// File: doc/ahb_dr_shift.md
Name: ahb_dr_shift

Overview:
- JTAG-side data-register front end for the AHB debug path, clocked on TCK.
- Shifts the AHB access command frame in from TDI and shifts status/read-data out on TDO.
- On Update-DR, decodes the frame and issues a single-outstanding request to the AHB master side, holding it until that side acknowledges.
- Directly upstream of the AHB register bit-counter stage; it shares the same select and update strobes.

Parameters:
- ADDR_W, 32, AHB address width.
- DATA_W, 32, payload / read-data width.
- CMD_W, 2, command field width.
- DR_W, CMD_W+DATA_W (34), shift register length (derived; do not override).

Ports:
- TCK  in  1  JTAG test clock.
- TRST  in  1  reset, asynchronous, active-high.
- TDI  in  1  serial data in.
- ahb_select  in  1  AHB data register selected by the IR.
- dr_capture  in  1  TAP in Capture-DR.
- dr_shift  in  1  TAP in Shift-DR.
- dr_update  in  1  TAP in Update-DR (one TCK pulse).
- tdo  out  1  serial data out, equal to sr[0].
- req  out  1  request pending to the AHB side (level).
- req_write  out  1  1 = write, 0 = read.
- req_addr  out  ADDR_W  transfer address.
- req_wdata  out  DATA_W  write data.
- ack  in  1  one-cycle completion pulse, already synchronised to TCK.
- ack_error  in  1  HRESP error for the completed transfer; valid with ack.
- ack_rdata  in  DATA_W  read data; valid with ack.
- busy  out  1  equals req.

Behaviour:
- Reset (TRST=1) clears all state:
  - sr, addr_q, wdata_q, rdata_q = 0.
  - req = 0, req_write = 0, err_q = 0, state = IDLE.
  - tdo = 0.
- Strobes are acted on only when ahb_select=1; otherwise the shift register holds.
- Capture (dr_capture=1): sr <= {err_q, busy, rdata_q}, i.e. the CMD_W field carries status {err, busy}.
  - Capture has priority over shift if both are asserted.
  - Capture clears err_q when state=IDLE.
- Shift (dr_shift=1): sr <= {TDI, sr[DR_W-1:1]}. LSB first; tdo is combinational from sr[0].
- Update: frame cmd = sr[DR_W-1:DATA_W], payload = sr[DATA_W-1:0].
  - 00 NOP: no effect.
  - 01 SET_ADDR: addr_q <= payload[ADDR_W-1:0]. Accepted in any state.
  - 10 WRITE: wdata_q <= payload; req_write=1; go to PEND.
  - 11 READ: req_write=0; go to PEND.
- FSM:
  - IDLE --(WRITE/READ update)--> PEND.
  - PEND --ack--> IDLE.
  - req = (state==PEND). req_addr/req_wdata/req_write stay stable for the whole of PEND.
- On ack in PEND:
  - rdata_q <= ack_rdata, for reads only.
  - err_q <= err_q | ack_error.
- ack while in IDLE is ignored.
- A WRITE or READ update arriving while in PEND, without ack in the same cycle, is an overrun:
  - the command is dropped;
  - err_q <= 1;
  - addr_q and wdata_q are unchanged.
- ack and update in the same cycle: the ack completes first, then the update is accepted. A WRITE/READ goes straight back to PEND, so req stays high.
- Latency: req rises on the TCK edge following the update cycle. Status becomes visible at the next Capture-DR.
- Reset mid-PEND drops the request immediately. The AHB side must tolerate req falling without ack.

Optional Feature:
- Macro: AHB_DR_AUTOINC_EN.
- Defined: on every ack of a WRITE or READ, addr_q <= addr_q + 4, wrapping modulo 2^ADDR_W. SET_ADDR in the same cycle as that ack takes priority over the increment.
- Undefined: addr_q changes only on SET_ADDR.

Decomposition:
- Shared package ahb_dbg_pkg holds:
  - typedef enum cmd_t {CMD_NOP, CMD_SETADDR, CMD_WRITE, CMD_READ};
  - typedef enum state_t {IDLE, PEND};
  - localparams ADDR_W, DATA_W, CMD_W, DR_W;
  - status bit indices ST_BUSY=0, ST_ERR=1.
- No sub-module needed; the shift register and FSM stay in one module. The interface signals may be bundled into the existing AHB-register interface as a new modport.

Test Plan:
- Reset check: assert TRST mid-shift -> tdo=0, req=0, busy=0. A following capture+shift of 34 bits reads all zeros.
- SET_ADDR then WRITE:
  - shift frame 01_0x40000010, update -> addr_q=0x40000010;
  - shift 10_0xDEADBEEF, update -> req=1 next edge, req_write=1, req_addr=0x40000010, req_wdata=0xDEADBEEF;
  - ack -> req=0.
- READ with data: READ update, then ack with ack_rdata=0x12345678, ack_error=0 -> capture+shift-out yields status 00, data 0x12345678, LSB first.
- Error/overrun:
  - a second WRITE update while PEND is dropped (req_wdata unchanged);
  - next capture shows status err=1, busy=1;
  - after ack, a capture shows err=1, and a further capture shows err=0.
- Simultaneous events:
  - ack and READ update in the same cycle -> req stays 1 with req_write=0;
  - ahb_select=0 with shift -> sr unchanged.
- With AHB_DR_AUTOINC_EN: addr 0xFFFFFFFC, WRITE, ack -> addr_q=0x00000000. Without the macro, addr_q stays 0xFFFFFFFC.
